// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared network dimensions, region selects and loader state encoding
package nn_pkg;

  localparam int N_IN_DEF  = 784;
  localparam int N_HID_DEF = 32;
  localparam int N_OUT_DEF = 10;

  typedef enum logic [1:0] {
    SEL_W1 = 2'd0,
    SEL_B1 = 2'd1,
    SEL_W2 = 2'd2,
    SEL_B2 = 2'd3
  } wr_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_W1 = 3'd1,
    ST_LD_B1 = 3'd2,
    ST_LD_W2 = 3'd3,
    ST_LD_B2 = 3'd4,
    ST_CHK   = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } wl_state_t;

  function automatic wr_sel_t sel_of(input wl_state_t s);
    case (s)
      ST_LD_B1: sel_of = SEL_B1;
      ST_LD_W2: sel_of = SEL_W2;
      ST_LD_B2: sel_of = SEL_B2;
      default:  sel_of = SEL_W1;
    endcase
  endfunction

endpackage

// File: rtl/wload_cksum.sv
// rtl/wload_cksum.sv - modulo-256 running sum of accepted weight/bias bytes
module wload_cksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] add_data,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        sum <= 8'd0;
    else if (clear)  sum <= 8'd0;
    else if (add_en) sum <= sum + add_data;
  end

endmodule

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams int8 weights/biases into W1/B1/W2/B2 regions
// Optional trailing checksum byte under `define WLOAD_CHECKSUM_EN.
module weight_loader
  import nn_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [1:0]  wr_sel,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [14:0] LAST_W1 = 15'(N_IN * N_HID - 1);
  localparam logic [14:0] LAST_B1 = 15'(N_HID - 1);
  localparam logic [14:0] LAST_W2 = 15'(N_HID * N_OUT - 1);
  localparam logic [14:0] LAST_B2 = 15'(N_OUT - 1);

  wl_state_t   state;
  logic [14:0] addr;
  logic [14:0] region_last;
  logic        accept;
  logic        last;

  assign accept = in_valid & in_ready;
  assign last   = (addr == region_last);

  always_comb begin
    region_last = LAST_W1;
    case (state)
      ST_LD_B1: region_last = LAST_B1;
      ST_LD_W2: region_last = LAST_W2;
      ST_LD_B2: region_last = LAST_B2;
      default:  region_last = LAST_W1;
    endcase
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [7:0] sum;

  // Only region bytes feed the sum; the checksum byte itself is compared, not added.
  wload_cksum u_cksum (
    .clk      (clk),
    .rst      (rst),
    .clear    (start & ~busy),
    .add_en   (accept & (state != ST_CHK)),
    .add_data (in_data),
    .sum      (sum)
  );
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      addr     <= 15'd0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_sel   <= 2'd0;
      wr_addr  <= 15'd0;
      wr_data  <= 8'd0;
`ifdef WLOAD_CHECKSUM_EN
      err      <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LD_W1;
            addr     <= 15'd0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
            err      <= 1'b0;
`endif
          end
        end
        ST_LD_W1, ST_LD_B1, ST_LD_W2, ST_LD_B2: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_sel  <= sel_of(state);
            wr_addr <= addr;
            wr_data <= in_data;
            addr    <= last ? 15'd0 : addr + 15'd1;
            if (last) begin
              case (state)
                ST_LD_W1: state <= ST_LD_B1;
                ST_LD_B1: state <= ST_LD_W2;
                ST_LD_W2: state <= ST_LD_B2;
                default: begin
`ifdef WLOAD_CHECKSUM_EN
                  state    <= ST_CHK;
`else
                  state    <= ST_DONE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
`endif
                end
              endcase
            end
          end
        end
`ifdef WLOAD_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == sum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - scoreboard and spot-table bench for weight_loader (WLOAD_CHECKSUM_EN aware)
module tb_weight_loader;

  localparam int N_IN  = 784;
  localparam int N_HID = 32;
  localparam int N_OUT = 10;
  localparam int W1_N  = N_IN * N_HID;
  localparam int B1_N  = N_HID;
  localparam int W2_N  = N_HID * N_OUT;
  localparam int TOTAL = W1_N + B1_N + W2_N + N_OUT;
`ifdef WLOAD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  weight_loader #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int          k;
    logic [1:0]  sel;
    logic [14:0] addr;
    logic [7:0]  data;
  } spot_t;

  wr_t  exp_q[$];
  wr_t  log_w[$];
  int   log_cyc[$];
  wr_t  last_w = '{2'd0, 15'd0, 8'd0};
  wr_t  mon_e;
  wr_t  mon_a;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] ck_sum = 8'd0;
  spot_t spots[8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic wr_t model(input int i);
    wr_t w;
    w.data = i[7:0];
    if (i < W1_N) begin
      w.sel = 2'd0; w.addr = 15'(i);
    end else if (i < W1_N + B1_N) begin
      w.sel = 2'd1; w.addr = 15'(i - W1_N);
    end else if (i < W1_N + B1_N + W2_N) begin
      w.sel = 2'd2; w.addr = 15'(i - W1_N - B1_N);
    end else begin
      w.sel = 2'd3; w.addr = 15'(i - W1_N - B1_N - W2_N);
    end
    return w;
  endfunction

  // Every write must match the oldest acceptance exactly one cycle later; idle outputs must hold.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      last_w = '{2'd0, 15'd0, 8'd0};
    end else begin
      mon_a = '{wr_sel, wr_addr, wr_data};
      if (wr_en || exp_q.size() != 0) begin
        n_checks++;
        if (!wr_en) begin
          n_errors++;
          $display("FAIL wr_latency: wr_en=0, required 1 for a pending write");
          mon_e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL wr_spurious: wr_en=1 sel=%0d addr=%0d, required no write", wr_sel, wr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            n_errors++;
            $display("FAIL wr_value: got sel=%0d addr=%0d data=%0h, required sel=%0d addr=%0d data=%0h",
                     wr_sel, wr_addr, wr_data, mon_e.sel, mon_e.addr, mon_e.data);
          end
        end
        if (wr_en) begin
          log_w.push_back(mon_a);
          log_cyc.push_back(cyc);
          last_w = mon_a;
        end
      end else begin
        n_checks++;
        if (mon_a !== last_w) begin
          n_errors++;
          $display("FAIL wr_hold: got sel=%0d addr=%0d data=%0h, required sel=%0d addr=%0d data=%0h",
                   wr_sel, wr_addr, wr_data, last_w.sel, last_w.addr, last_w.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_wr_en"}, wr_en, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_wr_sel"}, wr_sel, 0);
    chk({name, "_wr_addr"}, wr_addr, 0);
    chk({name, "_wr_data"}, wr_data, 0);
  endtask

  // Drives one load; returns early (reset asserted) once reset_at bytes have been accepted.
  task automatic run_stream(input bit gaps, input int start_at, input int reset_at, input bit bad_sum);
    int  idx = 0;
    int  guard = 0;
    int  n = TOTAL + (CK ? 1 : 0);
    bit  v;
    bit  pulsed = 1'b0;
    log_w.delete();
    log_cyc.delete();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    while (idx < n && guard < 120000) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (idx == reset_at) begin
        #2 rst = 1'b0;
        in_valid = 1'b0;
        #1 chk_all_zero("reset_mid");
        return;
      end
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid = v;
      in_data = (idx < TOTAL) ? 8'(idx) : (bad_sum ? ck_sum + 8'd1 : ck_sum);
      if (idx == start_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (v && in_ready) begin
        @(posedge clk);
        if (idx < TOTAL) exp_q.push_back(model(idx));
        idx++;
      end
    end
    chk("stream_timeout", guard < 120000, 1);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_spots(input string name);
    chk({name, "_write_count"}, log_w.size(), TOTAL);
    if (log_w.size() == TOTAL) begin
      foreach (spots[i]) begin
        chk($sformatf("%s_sel_%0d", name, spots[i].k), log_w[spots[i].k].sel, spots[i].sel);
        chk($sformatf("%s_addr_%0d", name, spots[i].k), log_w[spots[i].k].addr, spots[i].addr);
        chk($sformatf("%s_data_%0d", name, spots[i].k), log_w[spots[i].k].data, spots[i].data);
      end
    end
  endtask

  initial begin
    spots[0] = '{0,     2'd0, 15'd0,     8'h00};
    spots[1] = '{25087, 2'd0, 15'd25087, 8'hFF};
    spots[2] = '{25088, 2'd1, 15'd0,     8'h00};
    spots[3] = '{25119, 2'd1, 15'd31,    8'h1F};
    spots[4] = '{25120, 2'd2, 15'd0,     8'h20};
    spots[5] = '{25439, 2'd2, 15'd319,   8'h5F};
    spots[6] = '{25440, 2'd3, 15'd0,     8'h60};
    spots[7] = '{25449, 2'd3, 15'd9,     8'h69};
    for (int i = 0; i < TOTAL; i++) ck_sum = ck_sum + 8'(i);

    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Reset at byte 1000, then confirm nothing restarts without a new start.
    run_stream(1'b0, -1, 1000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (10) @(negedge clk);
    chk("post_reset_in_ready", in_ready, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_done", done, 0);
    in_valid = 1'b0;

    // Clean back-to-back stream.
    run_stream(1'b0, -1, -1, 1'b0);
    check_spots("clean");
    if (log_cyc.size() == TOTAL)
      chk("w1_b1_no_gap", log_cyc[25088] - log_cyc[25087], 1);
    chk("clean_done", done, 1);
    chk("clean_err", err, 0);
    chk("clean_busy", busy, 0);
    chk("clean_in_ready", in_ready, 0);
    chk("clean_hold_sel", wr_sel, 3);
    chk("clean_hold_addr", wr_addr, 9);
    chk("clean_hold_data", wr_data, 8'h69);

    // Random stalls plus a start pulse while busy; checksum build sends sum+1.
    run_stream(1'b1, 500, -1, CK);
    check_spots("gapped");
    chk("gapped_busy", busy, 0);
    chk("gapped_done", done, CK ? 0 : 1);
    chk("gapped_err", err, CK ? 1 : 0);
    chk("gapped_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameters N_IN, default 784, number of input features.
REQ-002 SHALL have parameters N_HID, default 32, number of hidden neurons.
REQ-003 SHALL have parameters N_OUT, default 10, number of output neurons.
REQ-004 SHALL have port clk, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins a load.
REQ-007 SHALL have port in_valid, input, 1, source byte valid.
REQ-008 SHALL have port in_data, input, 8, source byte (signed int8 weight/bias).
REQ-009 SHALL have port in_ready, output, 1, loader accepts byte.
REQ-010 SHALL have port wr_en, output, 1, memory write strobe.
REQ-011 SHALL have port wr_sel, output, 2, target region: 0=W1, 1=B1, 2=W2, 3=B2.
REQ-012 SHALL have port wr_addr, output, 15, region-local write address.
REQ-013 SHALL have port wr_data, output, 8, write byte.
REQ-014 SHALL have ports busy, done, err, output, 1 each: load in progress, load complete (sticky), load failed (sticky).

Function
REQ-015 SHALL transfer one byte when in_valid and in_ready are both high on a rising clk edge.
REQ-016 SHALL run states IDLE, LD_W1, LD_B1, LD_W2, LD_B2, CHK, DONE, ERR.
REQ-017 SHALL move from IDLE, DONE or ERR to LD_W1 on start, clearing done, err, the address counter and the checksum.
REQ-018 SHALL ignore start while busy.
REQ-019 SHALL drive in_ready high only in LD_W1, LD_B1, LD_W2, LD_B2 and CHK.
REQ-020 SHALL accept N_IN*N_HID bytes in LD_W1, N_HID in LD_B1, N_HID*N_OUT in LD_W2 and N_OUT in LD_B2, in that order, stored row-major with wr_addr = row*width + col.
REQ-021 SHALL wrap wr_addr to 0 and advance state on the same edge that accepts the last byte of a region.
REQ-022 SHALL register the write: wr_en, wr_sel, wr_addr and wr_data appear exactly one cycle after acceptance, with wr_en high for that one cycle only.
REQ-023 SHALL accept back-to-back bytes at one per cycle with no bubble, including across region boundaries.
REQ-024 SHALL hold state, address and outputs unchanged while in_valid is low (stall at any point).
REQ-025 SHALL assert busy in every state except IDLE, DONE and ERR.
REQ-026 SHALL hold wr_data, wr_addr and wr_sel at their last value when wr_en is low.

Reset
REQ-027 SHALL, on rst low, asynchronously enter IDLE with in_ready, wr_en, busy, done and err at 0, and wr_sel, wr_addr and wr_data at 0.
REQ-028 SHALL abandon a load on reset mid-transfer, issue no further writes, and require a new start.

Configuration
REQ-029 SHALL, with WLOAD_CHECKSUM_EN defined, keep an 8-bit modulo-256 sum of all accepted weight and bias bytes, and accept one extra byte in CHK after LD_B2.
REQ-030 SHALL, with WLOAD_CHECKSUM_EN defined, go to DONE (done=1) if that byte equals the sum, else to ERR (err=1); the checksum byte itself is never written.
REQ-031 SHALL, without WLOAD_CHECKSUM_EN, skip CHK, go to DONE from LD_B2's last byte, and tie err to 0.

Structure
REQ-032 SHALL take N_IN, N_HID and N_OUT defaults, region-select encodings and state encoding from the shared package nn_pkg, which is also used by the memory controller.
REQ-033 SHALL place the checksum accumulator in sub-module wload_cksum (clear, add-enable, byte in, sum out), instantiated only under WLOAD_CHECKSUM_EN.

Verification
REQ-034 SHALL test a full stream of 25450 bytes with value (index mod 256) and in_valid held high: it yields 25450 single-cycle writes; the W1 region ends at wr_addr 25087 and B2 ends at wr_addr 9; done=1; busy=0.
REQ-035 SHALL test a region boundary: the write after W1 address 25087 is wr_sel=1, wr_addr=0, in the next cycle with no gap.
REQ-036 SHALL test random in_valid gaps (about 50%): the write sequence is identical to REQ-034 and no write occurs during a stall.
REQ-037 SHALL test reset at byte 1000: all outputs are 0 immediately; a following start with a clean stream completes normally.
REQ-038 SHALL test, with WLOAD_CHECKSUM_EN, a correct sum byte giving done=1, err=0, and a sum byte plus 1 giving err=1, done=0; neither case writes the checksum byte.
REQ-039 SHALL test start pulsed while busy at byte 500: it has no effect and the load completes unchanged.
